add_pipe: RTL

Parametrised pipelined adder/subtractor, the successor to our 4-bit combinational adder. The carry chain is split into STAGES equal chunks, one register stage per chunk. A valid/ready handshake runs on both sides, so the block drops into streaming datapaths and tolerates backpressure. It provides a carry/borrow output and a signed-overflow flag; throughput is one operation per cycle.

---
 rtl/add_pipe_pkg.sv | 14 +
 rtl/add_pipe_stage.sv | 90 +++++++++
 rtl/add_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared helpers for the pipelined adder/subtractor.
//   stages_ok : true when STAGES is in 1..WIDTH and divides WIDTH evenly.
//   chunk_lsb : bit position of the low end of chunk idx.
package add_pipe_pkg;

  function automatic bit stages_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic int chunk_lsb(input int idx, input int cw);
    return idx * cw;
  endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// add_pipe_stage: one pipeline slot of add_pipe. Adds chunk IDX of the
// operands plus the incoming carry, merges the chunk into the running sum,
// and carries the full operands, carry and op bit forward.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_valid / o_ready    upstream handshake (o_ready = slot may load)
//   i_a, i_b             operand A and effective operand B (already inverted for sub)
//   i_sum                sum with chunks 0..IDX-1 already filled in
//   i_carry, i_op        carry into this chunk, subtract flag
//   o_valid / i_ready    downstream handshake
//   o_a, o_b, o_sum      registered operands and sum including chunk IDX
//   o_carry, o_op        registered carry out of chunk IDX, subtract flag
module add_pipe_stage
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_carry,
  input  logic             i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_op
);

  localparam int LSB = chunk_lsb(IDX, CW);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             op;
  } stage_t;

  stage_t           r_q;
  logic             w_load;
  logic [CW:0]      w_chunk;
  logic [WIDTH-1:0] w_sum_next;

  // The slot may take new contents when it is empty or its current
  // contents leave this cycle (bubble collapsing).
  assign w_load  = !r_q.valid || i_ready;
  assign o_ready = w_load;

  assign w_chunk = {1'b0, i_a[LSB +: CW]} + {1'b0, i_b[LSB +: CW]} + {{CW{1'b0}}, i_carry};

  always_comb begin
    w_sum_next = i_sum;
    w_sum_next[LSB +: CW] = w_chunk[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (w_load) begin
      r_q.valid <= i_valid;
      // Data only moves with a valid token, so undriven inputs on idle
      // cycles never reach the registers.
      if (i_valid) begin
        r_q.a     <= i_a;
        r_q.b     <= i_b;
        r_q.sum   <= w_sum_next;
        r_q.carry <= w_chunk[CW];
        r_q.op    <= i_op;
      end
    end
  end

  assign o_valid = r_q.valid;
  assign o_a     = r_q.a;
  assign o_b     = r_q.b;
  assign o_sum   = r_q.sum;
  assign o_carry = r_q.carry;
  assign o_op    = r_q.op;

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder/subtractor. The carry chain is cut
// into STAGES chunks of WIDTH/STAGES bits, one register slot per chunk.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_ready    input handshake
//   in_a, in_b, in_sub    operands; in_sub=1 selects A-B
//   out_valid, out_ready  output handshake
//   out_sum               [WIDTH-1:0] result, [WIDTH] carry (add) / borrow (sub)
//   out_ovf               signed two's-complement overflow
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready depends only on slot occupancy and
// out_ready, never on in_valid. A presented output holds its value until it
// is taken; results leave in acceptance order.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf
);

  localparam int CW = WIDTH / STAGES;

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("add_pipe: STAGES must be 1..WIDTH and divide WIDTH");
  end

  // Subtraction as A + ~B + 1: invert B and feed the op bit as carry-in.
  logic [WIDTH-1:0] w_b_eff;
  assign w_b_eff = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             w_in_valid;
    logic [WIDTH-1:0] w_in_a;
    logic [WIDTH-1:0] w_in_b;
    logic [WIDTH-1:0] w_in_sum;
    logic             w_in_carry;
    logic             w_in_op;
    logic             w_dn_ready;
    logic             w_up_ready;
    logic             w_valid;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_op;

    if (k == 0) begin : g_head
      assign w_in_valid = in_valid;
      assign w_in_a     = in_a;
      assign w_in_b     = w_b_eff;
      assign w_in_sum   = '0;
      assign w_in_carry = in_sub;
      assign w_in_op    = in_sub;
    end else begin : g_link
      assign w_in_valid = g_st[k-1].w_valid;
      assign w_in_a     = g_st[k-1].w_a;
      assign w_in_b     = g_st[k-1].w_b;
      assign w_in_sum   = g_st[k-1].w_sum;
      assign w_in_carry = g_st[k-1].w_carry;
      assign w_in_op    = g_st[k-1].w_op;
    end

    if (k == STAGES - 1) begin : g_tail
      assign w_dn_ready = out_ready;
    end else begin : g_next
      assign w_dn_ready = g_st[k+1].w_up_ready;
    end

    add_pipe_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_in_valid),
      .o_ready (w_up_ready),
      .i_a     (w_in_a),
      .i_b     (w_in_b),
      .i_sum   (w_in_sum),
      .i_carry (w_in_carry),
      .i_op    (w_in_op),
      .o_valid (w_valid),
      .i_ready (w_dn_ready),
      .o_a     (w_a),
      .o_b     (w_b),
      .o_sum   (w_sum),
      .o_carry (w_carry),
      .o_op    (w_op)
    );
  end

  logic [WIDTH-1:0] w_last_a;
  logic [WIDTH-1:0] w_last_b;
  logic [WIDTH-1:0] w_last_sum;
  logic             w_unused;

  assign in_ready   = g_st[0].w_up_ready;
  assign out_valid  = g_st[STAGES-1].w_valid;
  assign w_last_a   = g_st[STAGES-1].w_a;
  assign w_last_b   = g_st[STAGES-1].w_b;
  assign w_last_sum = g_st[STAGES-1].w_sum;

  // For subtract the final carry is the inverted borrow; XOR with the op
  // bit turns it into a borrow flag.
  assign out_sum = {g_st[STAGES-1].w_carry ^ g_st[STAGES-1].w_op, w_last_sum};

  // Same-sign operands (after B inversion) producing a different-sign result.
  assign out_ovf = (w_last_a[WIDTH-1] == w_last_b[WIDTH-1]) &&
                   (w_last_sum[WIDTH-1] != w_last_a[WIDTH-1]);

  // Only the MSBs of the retained operands matter at the output.
  assign w_unused = ^{w_last_a, w_last_b};

endmodule
